// File: rtl/key_wave_sel_pkg.sv
// Shared DDS constants: one-hot wave select codes, the waveform state
// encoding and the cyclic step function used by the selector FSM.
package key_wave_sel_pkg;

  localparam logic [3:0] WAVE_OFF      = 4'b0000;
  localparam logic [3:0] WAVE_SINE     = 4'b0001;
  localparam logic [3:0] WAVE_SQUARE   = 4'b0010;
  localparam logic [3:0] WAVE_TRIANGLE = 4'b0100;
  localparam logic [3:0] WAVE_SAWTOOTH = 4'b1000;

  // State codes equal the wave codes so wave_sel is the state register itself.
  typedef enum logic [3:0] {
    ST_OFF      = WAVE_OFF,
    ST_SINE     = WAVE_SINE,
    ST_SQUARE   = WAVE_SQUARE,
    ST_TRIANGLE = WAVE_TRIANGLE,
    ST_SAWTOOTH = WAVE_SAWTOOTH
  } wave_state_e;

  function automatic logic is_legal_state(input logic [3:0] s);
    logic ok;
    case (s)
      WAVE_OFF, WAVE_SINE, WAVE_SQUARE,
      WAVE_TRIANGLE, WAVE_SAWTOOTH: ok = 1'b1;
      default:                      ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic wave_state_e step_wave(input wave_state_e cur, input logic fwd);
    wave_state_e nxt;
    case (cur)
      ST_OFF:      nxt = fwd ? ST_SINE     : ST_SAWTOOTH;
      ST_SINE:     nxt = fwd ? ST_SQUARE   : ST_OFF;
      ST_SQUARE:   nxt = fwd ? ST_TRIANGLE : ST_SINE;
      ST_TRIANGLE: nxt = fwd ? ST_SAWTOOTH : ST_SQUARE;
      ST_SAWTOOTH: nxt = fwd ? ST_OFF      : ST_TRIANGLE;
      default:     nxt = ST_OFF;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/key_wave_sel_key_filter.sv
// Push-button conditioner: 2-flop synchronizer, saturating low-level debounce
// counter and a registered one-cycle press pulse per qualified press.
module key_filter #(
  parameter int CNT_MAX = 999_999
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in,
  output logic key_press
);

  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(CNT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  // Pulse fires only on the CNT_MAX-1 -> CNT_MAX step, so a held key saturates silently.
  always_comb begin
    cnt_d   = cnt_q;
    press_d = 1'b0;
    if (sync2_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_TOP) begin
      cnt_d   = cnt_q + CNT_ONE;
      press_d = (cnt_q == CNT_PRE);
    end else begin
      cnt_d = CNT_TOP;
    end
  end

  // Synchronizer resets to the released (high) level.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign key_press = press_q;

endmodule

// File: rtl/key_wave_sel.sv
// Waveform selector: two debounced keys step a five-state one-hot FSM whose
// register drives the DDS wave select directly.
module key_wave_sel
  import key_wave_sel_pkg::*;
#(
  parameter int CNT_MAX = 999_999
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       key_next,
  input  logic       key_prev,
  output logic [3:0] wave_sel,
  output logic       key_flag
);

  logic        next_press, prev_press;
  wave_state_e state_q;
  logic        key_flag_q;

  key_filter #(.CNT_MAX(CNT_MAX)) u_filter_next (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_in    (key_next),
    .key_press (next_press)
  );

  key_filter #(.CNT_MAX(CNT_MAX)) u_filter_prev (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_in    (key_prev),
    .key_press (prev_press)
  );

  // Simultaneous presses cancel; a corrupted state register falls back to OFF.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_OFF;
      key_flag_q <= 1'b0;
    end else begin
      key_flag_q <= 1'b0;
      if (!is_legal_state(state_q)) begin
        state_q <= ST_OFF;
      end else if (next_press ^ prev_press) begin
        state_q    <= step_wave(state_q, next_press);
        key_flag_q <= 1'b1;
      end else begin
        state_q <= state_q;
      end
    end
  end

  assign wave_sel = state_q;
  assign key_flag = key_flag_q;

endmodule

// File: tb/tb_key_wave_sel.sv
// Directed bench for key_wave_sel (CNT_MAX=20): stimulus pushes the expected
// wave code and flag cycle; a negedge monitor pops and compares on key_flag.
module tb_key_wave_sel;

  localparam int CNT_MAX = 20;
  localparam int LAT     = CNT_MAX + 3;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       key_next;
  logic       key_prev;
  logic [3:0] wave_sel;
  logic       key_flag;

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] wave;
    int         cyc;
  } exp_t;
  exp_t exp_q[$];

  key_wave_sel #(.CNT_MAX(CNT_MAX)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_next  (key_next),
    .key_prev  (key_prev),
    .wave_sel  (wave_sel),
    .key_flag  (key_flag)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Monitor: one-hot invariant every cycle, scoreboard pop on each key_flag.
  always @(negedge sys_clk) begin
    exp_t e;
    if (sys_rst_n) begin
      checks++;
      if (!$onehot0(wave_sel)) begin
        failures++;
        $display("FAIL onehot0 wave_sel=%b cyc=%0d", wave_sel, cyc);
      end
    end
    if (key_flag) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_flag actual wave_sel=%b cyc=%0d, required no flag", wave_sel, cyc);
      end else begin
        e = exp_q.pop_front();
        if (wave_sel !== e.wave || cyc != e.cyc) begin
          failures++;
          $display("FAIL flag_event actual wave=%b cyc=%0d, required wave=%b cyc=%0d",
                   wave_sel, cyc, e.wave, e.cyc);
        end
      end
    end else if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
      checks++;
      failures++;
      $display("FAIL missing_flag no key_flag by cyc=%0d, required wave=%b at cyc=%0d",
               cyc, exp_q[0].wave, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic expect_flag(input logic [3:0] wave, input int at);
    exp_t e;
    e.wave = wave;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  logic [3:0] next_seq [5];

  initial begin
    next_seq[0] = 4'b0001;
    next_seq[1] = 4'b0010;
    next_seq[2] = 4'b0100;
    next_seq[3] = 4'b1000;
    next_seq[4] = 4'b0000;

    sys_rst_n = 1'b0;
    key_next  = 1'b1;
    key_prev  = 1'b1;

    // Reset held 10 cycles
    for (int i = 0; i < 10; i++) begin
      @(negedge sys_clk);
      check4("reset_wave_sel", wave_sel, 4'b0000);
      check4("reset_key_flag", {3'b000, key_flag}, 4'b0000);
    end
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    tick(5);

    // Five next presses walk the full cycle back to OFF
    for (int i = 0; i < 5; i++) begin
      key_next = 1'b0;
      expect_flag(next_seq[i], cyc + LAT);
      tick(30);
      key_next = 1'b1;
      tick(10);
    end
    check4("after_next_cycle", wave_sel, 4'b0000);

    // Bounce: six 8-cycle lows split by 3-cycle highs
    for (int i = 0; i < 6; i++) begin
      key_next = 1'b0;
      tick(8);
      key_next = 1'b1;
      tick(3);
    end
    tick(40);
    check4("after_bounce", wave_sel, 4'b0000);

    // Long prev hold from OFF: one step to sawtooth
    key_prev = 1'b0;
    expect_flag(4'b1000, cyc + LAT);
    tick(100);
    check4("prev_held", wave_sel, 4'b1000);
    key_prev = 1'b1;
    tick(10);

    // Both keys together: cancelled
    key_next = 1'b0;
    key_prev = 1'b0;
    tick(30);
    key_next = 1'b1;
    key_prev = 1'b1;
    tick(10);
    check4("both_keys", wave_sel, 4'b1000);

    // Reset at count 15 while next is held; full period needed afterwards
    key_next = 1'b0;
    tick(17);
    sys_rst_n = 1'b0;
    #1;
    check4("midpress_reset_wave", wave_sel, 4'b0000);
    check4("midpress_reset_flag", {3'b000, key_flag}, 4'b0000);
    tick(2);
    sys_rst_n = 1'b1;
    expect_flag(4'b0001, cyc + LAT);
    tick(40);
    key_next = 1'b1;
    tick(10);
    check4("after_reset_press", wave_sel, 4'b0001);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d pending required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_wave_sel.md
KEY_WAVE_SEL -- requirements
Module: key_wave_sel

Interface
REQ-001 The block SHALL have parameter CNT_MAX, default 999_999 (20 ms at 50 MHz): number of consecutive stable-low clock cycles that qualify a key press.
REQ-002 The block SHALL have port sys_clk  input  1  system clock (50 MHz); all state changes on its rising edge.
REQ-003 The block SHALL have port sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port key_next  input  1  raw push-button, active-low, asynchronous to sys_clk, bouncing; selects the next waveform.
REQ-005 The block SHALL have port key_prev  input  1  raw push-button, active-low, asynchronous, bouncing; selects the previous waveform.
REQ-006 The block SHALL have port wave_sel  output  4  one-hot waveform select to the DDS stage: 0000 off, 0001 sine, 0010 square, 0100 triangle, 1000 sawtooth.
REQ-007 The block SHALL have port key_flag  output  1  one-cycle pulse on every accepted waveform change.

Function
REQ-008 Each key SHALL pass through a 2-flop synchronizer before any other logic.
REQ-009 Each key SHALL have a debounce counter: it clears to 0 while the synchronized level is high, increments while low, and saturates at CNT_MAX.
REQ-010 A per-key press pulse SHALL be high for exactly one cycle, the cycle in which the counter steps from CNT_MAX-1 to CNT_MAX; a held key SHALL yield exactly one pulse until it is released (high for at least one synchronized cycle).
REQ-011 A low glitch shorter than CNT_MAX cycles SHALL produce no pulse.
REQ-012 The state machine SHALL have five states, OFF, SINE, SQUARE, TRIANGLE and SAWTOOTH, with wave_sel driven directly from the one-hot state register.
REQ-013 A next pulse SHALL advance the state cyclically: OFF->SINE->SQUARE->TRIANGLE->SAWTOOTH->OFF.
REQ-014 A prev pulse SHALL step the state backwards: OFF->SAWTOOTH->TRIANGLE->SQUARE->SINE->OFF.
REQ-015 A next pulse and a prev pulse in the same cycle SHALL be ignored: state unchanged, key_flag low.
REQ-016 wave_sel SHALL change at the clock edge following the press pulse; key_flag SHALL be high during the first cycle the new wave_sel is valid.
REQ-017 Total latency SHALL be 2 (synchronizer) + CNT_MAX + 1 cycles from the first sampled stable-low edge to the wave_sel change.
REQ-018 Any state register value that is not a legal state SHALL recover to OFF on the next clock.
REQ-019 wave_sel SHALL never hold more than one bit set.

Reset
REQ-020 While sys_rst_n is low, the following SHALL hold: wave_sel=0000, key_flag=0, debounce counters=0, synchronizer flops=1 (released level).
REQ-021 Reset asserted mid-press SHALL discard the partial count; after release of reset, a key that is still held SHALL require a full CNT_MAX low period before it is accepted.

Structure
REQ-022 The one-hot wave codes and the state encodings SHALL live in the shared DDS package, so that this block and dds_ctrl use identical constants.
REQ-023 The synchronizer and debounce logic SHALL be one sub-module, key_filter (parameter CNT_MAX; ports sys_clk, sys_rst_n, key_in, key_press), instantiated once per key.
REQ-024 The state machine SHALL be in the top module.

Verification (run with CNT_MAX=20)
REQ-025 The bench SHALL cover: reset held 10 cycles, keys high -> wave_sel=0000, key_flag=0 throughout.
REQ-026 The bench SHALL cover: key_next low 30 cycles then high, repeated 5 times -> wave_sel 0001, 0010, 0100, 1000, 0000; key_flag pulses exactly once per press, 23 cycles after the press.
REQ-027 The bench SHALL cover: key_next bouncing, 6 low pulses of 8 cycles separated by 3-cycle highs, then high -> no key_flag, wave_sel unchanged.
REQ-028 The bench SHALL cover: from OFF, key_prev held 100 cycles -> single key_flag, wave_sel=1000, no further change while held.
REQ-029 The bench SHALL cover: both keys pressed on the same cycle and held 30 cycles -> pulses coincide, wave_sel unchanged, key_flag stays 0.
REQ-030 The bench SHALL cover: key_next held, reset pulsed at count 15, key still held -> wave_sel=0000 at reset; first change to 0001 occurs 23 cycles after reset release.
